// File: rtl/fifo_pkg.sv
// Shared constants and Gray/binary helpers for the dual-clock Gray-pointer FIFO.
// Used by both the write-side full block and the read-side empty block.
package fifo_pkg;

    // Widest pointer the helper functions handle; callers truncate the result.
    localparam int unsigned FIFO_PTR_MAXW = 32;

    // Number of words for a given address width.
    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

    // Binary to reflected Gray code; zero-extended inputs stay correct.
    function automatic logic [FIFO_PTR_MAXW-1:0] bin2gray(input logic [FIFO_PTR_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    function automatic logic [FIFO_PTR_MAXW-1:0] gray2bin(input logic [FIFO_PTR_MAXW-1:0] g);
        logic [FIFO_PTR_MAXW-1:0] b;
        b = '0;
        b[FIFO_PTR_MAXW-1] = g[FIFO_PTR_MAXW-1];
        for (int i = FIFO_PTR_MAXW-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of parametrised width.
// Bit i of the result is the XOR-reduction of Gray bits W-1 down to i.
module fifo_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Prefix XOR from the MSB down, one reduction per output bit.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign o_bin[gi] = ^i_gray[W-1:gi];
    end

endmodule

// File: rtl/fifo_wptr_full_prog.sv
// Write-side pointer and flag generator for the dual-clock Gray FIFO.
// Provides a programmable almost-full threshold, a registered fill level and,
// when FIFO_WPTR_OVF_EN is defined, a sticky overflow flag with clear input.
module fifo_wptr_full_prog
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = 4,
    parameter int AFULL_RST = (1 << ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   afull_thr,
    input  logic                afull_ld,
`ifdef FIFO_WPTR_OVF_EN
    input  logic                wovf_clr,
`endif
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wen,
    output logic                wfull,
    output logic                awfull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic          r_wfull;
    logic          r_awfull;
    logic [PW-1:0] r_wlevel;
    logic [PW-1:0] r_thr;

    logic [PW-1:0] w_rbin;
    logic          w_wen;
    logic [PW-1:0] w_wbinnext;
    logic [PW-1:0] w_wgraynext;
    logic [PW-1:0] w_levnext;
    logic [PW-1:0] w_rptr_full;
    logic          w_full_next;
    logic          w_afull_next;

    // Synchronised read pointer back to binary for level arithmetic.
    fifo_gray2bin #(.W(PW)) u_rptr_g2b (
        .i_gray (wq2_rptr),
        .o_bin  (w_rbin)
    );

    assign w_wen       = winc & ~r_wfull;
    assign w_wbinnext  = r_wbin + PW'(w_wen);
    assign w_wgraynext = PW'(bin2gray(FIFO_PTR_MAXW'(w_wbinnext)));
    // Level wraps modulo 2^PW, which keeps it correct across pointer wrap.
    assign w_levnext   = w_wbinnext - w_rbin;
    // Full when the write pointer equals the read pointer with the top two Gray bits inverted.
    assign w_rptr_full  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    assign w_full_next  = (w_wgraynext == w_rptr_full);
    assign w_afull_next = (w_levnext >= r_thr);

    // Pointer, level, flag and threshold registers.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wbin   <= '0;
            r_wptr   <= '0;
            r_wfull  <= 1'b0;
            r_awfull <= (AFULL_RST == 0);
            r_wlevel <= '0;
            r_thr    <= PW'(AFULL_RST);
        end else begin
            r_wbin   <= w_wbinnext;
            r_wptr   <= w_wgraynext;
            r_wfull  <= w_full_next;
            r_awfull <= w_afull_next;
            r_wlevel <= w_levnext;
            // New threshold is seen by awfull from the following edge on.
            if (afull_ld) begin
                r_thr <= afull_thr;
            end
        end
    end

`ifdef FIFO_WPTR_OVF_EN
    logic r_wovf;

    // Sticky overflow: a write attempt while full; a new set beats a clear.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wovf <= 1'b0;
        end else begin
            r_wovf <= (r_wovf & ~wovf_clr) | (winc & r_wfull);
        end
    end

    assign wovf = r_wovf;
`else
    assign wovf = 1'b0;
`endif

    assign waddr  = r_wbin[ADDRSIZE-1:0];
    assign wptr   = r_wptr;
    assign wen    = w_wen;
    assign wfull  = r_wfull;
    assign awfull = r_awfull;
    assign wlevel = r_wlevel;

endmodule
